// File: rtl/ps2_mouse_host_if.sv
// PS/2 bus as seen by the host block.
//   ps2_clk_i / ps2_data_i   : sensed clock / data lines (asynchronous to clk_sys)
//   ps2_clk_oe / ps2_data_oe : 1 = pull the line low, 0 = release (open collector)
// master = host side, slave = device / bus model side.
interface ps2_mouse_host_if;
    logic ps2_clk_i;
    logic ps2_data_i;
    logic ps2_clk_oe;
    logic ps2_data_oe;

    modport master (
        input  ps2_clk_i,
        input  ps2_data_i,
        output ps2_clk_oe,
        output ps2_data_oe
    );

    modport slave (
        output ps2_clk_i,
        output ps2_data_i,
        input  ps2_clk_oe,
        input  ps2_data_oe
    );
endinterface

// File: rtl/ps2_mouse_host.sv
// PS/2 mouse host: sends Enable Data Reporting (0xF4), waits for the 0xFA
// acknowledge, then assembles 3-byte stream packets.
//   clk_sys    : system clock, all logic on its rising edge
//   reset_n    : asynchronous active-low reset
//   ps2        : PS/2 clock/data lines (sensed inputs, open-collector enables)
//   ps2_mouse  : [7:0] status, [15:8] X, [23:16] Y, [24] toggles per packet
//   init_done  : high once the device has acknowledged 0xF4
module ps2_mouse_host #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    ps2_mouse_host_if.master ps2,
    output logic [24:0]      ps2_mouse,
    output logic             init_done
);

    typedef enum logic [2:0] {
        S_INHIBIT, S_REQ, S_TX, S_TX_ACK, S_WAIT_FA, S_STREAM
    } state_t;

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Transmit sequence indexed by edge count: 0xF4 LSB first, parity 0, stop 1.
    localparam logic [9:0] TX_FRAME = 10'b1_0_1111_0100;
    localparam logic [7:0] ACK_BYTE = 8'hFA;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_prev_q;
    logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shreg_q, shreg_d;
    logic            tx_oe_q, tx_oe_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      byte0_q, byte0_d, byte1_q, byte1_d;
    logic [24:0]     mouse_q, mouse_d;
    logic            init_q, init_d;

    logic            clk_s, dat_s, fall;
    logic            inh_done, to_active, timeout;
    logic            rx_done, rx_ok, tx_last;
    logic [10:0]     rx_frame;
    logic [7:0]      rx_byte;

    // Synchronizers idle high so reset release never looks like a clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2.ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2.ps2_data_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign fall     = clk_prev_q & ~clk_s;

    assign inh_done = (inh_cnt_q == IW'(INHIBIT_CYC - 1));
    assign tx_last  = (bit_cnt_q == 4'd9);
    assign rx_done  = fall && (bit_cnt_q == 4'd10);
    // Current data sample completes the frame: [0] start .. [10] stop.
    assign rx_frame = {dat_s, shreg_q};
    assign rx_byte  = rx_frame[8:1];
    assign rx_ok    = !rx_frame[0] && rx_frame[10] && (^rx_frame[9:1]);

    // Watchdog runs during the handshake, and in stream only while a frame
    // or packet is partially received.
    assign to_active = (state_q == S_TX) || (state_q == S_TX_ACK) ||
                       (state_q == S_WAIT_FA) ||
                       ((state_q == S_STREAM) && ((bit_cnt_q != 4'd0) || (idx_q != 2'd0)));
    assign timeout   = to_active && !fall && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= S_INHIBIT;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INHIBIT: if (inh_done) state_d = S_REQ;
            S_REQ:     state_d = S_TX;
            S_TX: begin
                if (fall && tx_last) state_d = S_TX_ACK;
                else if (timeout)    state_d = S_INHIBIT;
            end
            S_TX_ACK: begin
                if (fall)         state_d = dat_s ? S_INHIBIT : S_WAIT_FA;
                else if (timeout) state_d = S_INHIBIT;
            end
            S_WAIT_FA: begin
                if (rx_done)      state_d = (rx_ok && rx_byte == ACK_BYTE) ? S_STREAM : S_INHIBIT;
                else if (timeout) state_d = S_INHIBIT;
            end
            S_STREAM:  state_d = S_STREAM;
            default:   state_d = S_INHIBIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ps2.ps2_clk_oe  = (state_q == S_INHIBIT);
        ps2.ps2_data_oe = (state_q == S_REQ) || ((state_q == S_TX) && tx_oe_q);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_oe_d   = tx_oe_q;
        idx_d     = idx_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        mouse_d   = mouse_q;
        init_d    = init_q;

        if ((state_q == S_INHIBIT) && !inh_done) inh_cnt_d = inh_cnt_q + IW'(1);
        if (to_active && !fall && !timeout)     to_cnt_d  = to_cnt_q + TW'(1);

        case (state_q)
            S_INHIBIT: begin
                bit_cnt_d = '0;
                tx_oe_d   = 1'b0;
            end
            S_REQ: begin
                bit_cnt_d = '0;
                tx_oe_d   = 1'b1;    // start bit held until the first device edge
            end
            S_TX: begin
                if (fall) begin
                    tx_oe_d   = ~TX_FRAME[bit_cnt_q];
                    bit_cnt_d = tx_last ? 4'd0 : bit_cnt_q + 4'd1;
                end
            end
            S_TX_ACK: begin
                bit_cnt_d = '0;
                tx_oe_d   = 1'b0;
            end
            S_WAIT_FA, S_STREAM: begin
                if (fall) begin
                    shreg_d   = {dat_s, shreg_q[9:1]};
                    bit_cnt_d = rx_done ? 4'd0 : bit_cnt_q + 4'd1;
                end else if (timeout) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                end
                if (rx_done) begin
                    if (state_q == S_WAIT_FA) begin
                        if (rx_ok && rx_byte == ACK_BYTE) init_d = 1'b1;
                        idx_d = '0;
                    end else if (!rx_ok) begin
                        idx_d = '0;
                    end else begin
                        case (idx_q)
                            2'd0: begin
                                // Bit 3 of the status byte is always set; drop
                                // anything else to find the packet boundary.
                                if (rx_byte[3]) begin
                                    byte0_d = rx_byte;
                                    idx_d   = 2'd1;
                                end
                            end
                            2'd1: begin
                                byte1_d = rx_byte;
                                idx_d   = 2'd2;
                            end
                            2'd2: begin
                                mouse_d = {~mouse_q[24], rx_byte, byte1_q, byte0_q};
                                idx_d   = 2'd0;
                            end
                            default: idx_d = 2'd0;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_oe_q   <= 1'b0;
            idx_q     <= '0;
            byte0_q   <= '0;
            byte1_q   <= '0;
            mouse_q   <= '0;
            init_q    <= 1'b0;
        end else begin
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_oe_q   <= tx_oe_d;
            idx_q     <= idx_d;
            byte0_q   <= byte0_d;
            byte1_q   <= byte1_d;
            mouse_q   <= mouse_d;
            init_q    <= init_d;
        end
    end

    assign ps2_mouse = mouse_q;
    assign init_done = init_q;

endmodule

// File: tb/tb_ps2_mouse_host.sv
// Bench for ps2_mouse_host: an open-collector bus model plus a PS/2 mouse
// device model driven from a table of stream bytes, with hand-written
// sequences for initialization, retry and mid-packet reset.
`timescale 1ns/1ps
module tb_ps2_mouse_host;
    localparam int INH  = 5000;
    localparam int TO   = 3000;
    localparam int HALF = 15;

    typedef struct {
        logic [7:0]  b;
        bit          bad_par;
        bit          bad_stop;
        int          nbits;
        int          gap;
        bit          chk;
        logic [23:0] exp_d;
        int          exp_tog;
    } vec_t;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        dev_clk  = 1'b1;
    logic        dev_data = 1'b1;
    logic [24:0] ps2_mouse;
    logic        init_done;

    int nvec = 0;
    int nerr = 0;

    ps2_mouse_host_if bus();

    // Wired-AND: either side may pull a line low.
    assign bus.ps2_clk_i  = dev_clk  & ~bus.ps2_clk_oe;
    assign bus.ps2_data_i = dev_data & ~bus.ps2_data_oe;

    ps2_mouse_host #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2      (bus),
        .ps2_mouse(ps2_mouse),
        .init_done(init_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Toggle counter, partial-update detector and inhibit-length measurement.
    logic [24:0] prev_mouse = '0;
    int toggles  = 0;
    int partial  = 0;
    int run_cnt  = 0;
    int last_run = 0;

    always @(negedge clk_sys) begin
        prev_mouse <= ps2_mouse;
        if (!reset_n) begin
            toggles <= 0;
            run_cnt <= 0;
        end else begin
            if (ps2_mouse[24] != prev_mouse[24])         toggles <= toggles + 1;
            else if (ps2_mouse[23:0] != prev_mouse[23:0]) partial <= partial + 1;
            if (bus.ps2_clk_oe) run_cnt <= run_cnt + 1;
            else if (run_cnt != 0) begin
                last_run <= run_cnt;
                run_cnt  <= 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", nvec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic release_reset();
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    // Device side of a host-to-device transfer: wait for inhibit, clock out
    // the 10 host bits, then acknowledge.
    task automatic host_capture(input string tag);
        int n;
        logic [9:0] bits;
        bits = '0;
        n = 0;
        while (!bus.ps2_clk_oe && n < 30000) begin @(negedge clk_sys); n++; end
        check({tag, "_inhibit_seen"}, 32'(bus.ps2_clk_oe), 32'd1);
        n = 0;
        while (bus.ps2_clk_oe && n < 30000) begin @(negedge clk_sys); n++; end
        check({tag, "_req"}, 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd1);
        @(negedge clk_sys);
        check({tag, "_inhibit_len"}, 32'(last_run), 32'(INH));
        wait_cyc(HALF);
        check({tag, "_start_bit"}, 32'(bus.ps2_data_i), 32'd0);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            wait_cyc(HALF);
            dev_clk = 1'b1;
            bits[i] = bus.ps2_data_i;
            wait_cyc(HALF);
        end
        check({tag, "_tx_bits"}, 32'(bits), 32'h2F4);
        dev_data = 1'b0;
        wait_cyc(HALF);
        dev_clk = 1'b0;
        wait_cyc(HALF);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_cyc(HALF);
    endtask

    // Device-to-host frame; nbits < 11 truncates the frame.
    task automatic dev_send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data = fr[i];
            wait_cyc(HALF);
            dev_clk = 1'b0;
            wait_cyc(HALF);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        wait_cyc(HALF);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input bit bp, input bit bs, input int nb,
                                input int gap, input bit chk, input logic [23:0] ed, input int et);
        vec_t v;
        v.b = b; v.bad_par = bp; v.bad_stop = bs; v.nbits = nb;
        v.gap = gap; v.chk = chk; v.exp_d = ed; v.exp_tog = et;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        // byte, bad parity, bad stop, bits, idle after, check, expected data, toggles
        vt.push_back(mk(8'h09, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h05, 0, 0, 11, 0,      1, 24'h000000, 0));
        vt.push_back(mk(8'hFB, 0, 0, 11, 0,      1, 24'hFB0509, 1));
        vt.push_back(mk(8'h00, 0, 0, 11, 0,      1, 24'hFB0509, 1));
        vt.push_back(mk(8'h08, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h01, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h02, 0, 0, 11, 0,      1, 24'h020108, 2));
        vt.push_back(mk(8'h18, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'hAA, 1, 0, 11, 0,      1, 24'h020108, 2));
        vt.push_back(mk(8'h18, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'hFF, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h01, 0, 0, 11, 0,      1, 24'h01FF18, 3));
        vt.push_back(mk(8'h08, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h10, 0, 0, 11, TO + 1, 1, 24'h01FF18, 3));
        vt.push_back(mk(8'h08, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h10, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h20, 0, 0, 11, 0,      1, 24'h201008, 4));
        vt.push_back(mk(8'h28, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h44, 0, 1, 11, 0,      1, 24'h201008, 4));
        vt.push_back(mk(8'h09, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h07, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h06, 0, 0, 11, 0,      1, 24'h060709, 5));
        vt.push_back(mk(8'hFF, 0, 0, 5,  TO + 1, 1, 24'h060709, 5));
        vt.push_back(mk(8'h0C, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h01, 0, 0, 11, 0,      0, 24'h000000, 0));
        vt.push_back(mk(8'h02, 0, 0, 11, 0,      1, 24'h02010C, 6));

        // Reset state
        wait_cyc(3);
        check("rst_mouse",   32'(ps2_mouse),       32'd0);
        check("rst_init",    32'(init_done),       32'd0);
        check("rst_clk_oe",  32'(bus.ps2_clk_oe),  32'd1);
        check("rst_data_oe", 32'(bus.ps2_data_oe), 32'd0);

        // Initialization
        release_reset();
        host_capture("init");
        check("init_before_fa", 32'(init_done), 32'd0);
        dev_send(8'hFA, 0, 0, 11);
        wait_cyc(4);
        check("init_done", 32'(init_done), 32'd1);
        check("stream_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);

        // Stream vectors
        for (int i = 0; i < vt.size(); i++) begin
            dev_send(vt[i].b, vt[i].bad_par, vt[i].bad_stop, vt[i].nbits);
            wait_cyc(vt[i].gap);
            if (vt[i].chk) begin
                check($sformatf("vec%0d_data", i), 32'(ps2_mouse[23:0]), 32'(vt[i].exp_d));
                check($sformatf("vec%0d_toggles", i), 32'(toggles), 32'(vt[i].exp_tog));
            end
        end
        check("init_held", 32'(init_done), 32'd1);

        // Reset in the middle of a packet and a frame
        dev_send(8'h08, 0, 0, 11);
        dev_send(8'h11, 0, 0, 11);
        dev_send(8'h22, 0, 0, 5);
        @(negedge clk_sys);
        reset_n = 1'b0;
        wait_cyc(2);
        check("mid_rst_mouse",   32'(ps2_mouse),       32'd0);
        check("mid_rst_init",    32'(init_done),       32'd0);
        check("mid_rst_clk_oe",  32'(bus.ps2_clk_oe),  32'd1);
        check("mid_rst_data_oe", 32'(bus.ps2_data_oe), 32'd0);

        // Re-initialization with a resend request first
        release_reset();
        host_capture("first");
        dev_send(8'hFE, 0, 0, 11);
        wait_cyc(2);
        check("retry_no_init", 32'(init_done), 32'd0);
        host_capture("retry");
        dev_send(8'hFA, 0, 0, 11);
        wait_cyc(4);
        check("retry_init_done", 32'(init_done), 32'd1);

        dev_send(8'h0A, 0, 0, 11);
        dev_send(8'h03, 0, 0, 11);
        dev_send(8'h04, 0, 0, 11);
        check("post_rst_data",    32'(ps2_mouse[23:0]), 32'h04030A);
        check("post_rst_toggles", 32'(toggles),         32'd1);
        check("no_partial_updates", 32'(partial),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
